avalon_pio_ctrl: RTL and testbench
==================================

# avalon_pio_ctrl

Parametrised Avalon-MM slave parallel I/O block for the HPS-to-FPGA control path of the LBM accelerator. It drives run/print/start strobes to the fabric and captures status flags from it. It provides a DATA_W-bit output register with atomic set/clear, a self-timed pulse mode for one-shot triggers, and a 2-flop-synchronised input port. Optional rising-edge capture on the input port can raise an interrupt to the HPS.

## Interface
- DATA_W, 8, width of out_port/in_port and all data registers (1..32)
- PULSE_W, 8, width of the pulse length counter (1..16)
- RESET_VALUE, 0, reset value of the output register (DATA_W bits)

- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low; one clock domain only
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above DATA_W (or PULSE_W) ignored
- readdata  out  32  read data; unused upper bits 0
- in_port  in  DATA_W  asynchronous status inputs from the fabric
- out_port  out  DATA_W  control outputs, equal to the data register
- irq  out  1  level interrupt to the HPS

## Operation
- A write occurs when chipselect=1 and write_n=0. Reads have zero wait states: readdata is combinational from address and register state. There are no read side effects.
- Register map (word address):
  - 0 DATA: R/W output register.
  - 1 IN: RO synchronised in_port.
  - 2 SET: WO; DATA |= wd. Reads 0.
  - 3 CLR: WO; DATA &= ~wd. Reads 0.
  - 4 EDGE: RW1C rising-edge capture.
  - 5 IRQMASK: R/W.
  - 6 PULSE_LEN: R/W, PULSE_W bits.
  - 7 PULSE: a write ORs wd into DATA and into pulse_mask, and loads the counter with PULSE_LEN. A PULSE_LEN of 0 is treated as 1. A read returns the remaining count.
- Pulse engine:
  - States are IDLE (count=0) and ACTIVE (count>0).
  - ACTIVE decrements once per cycle.
  - On the 1→0 transition (expiry), DATA &= ~pulse_mask and pulse_mask is cleared.
  - A PULSE write while ACTIVE ORs in the new mask and reloads the counter (retrigger).
- Same-cycle priority at expiry:
  - With a DATA write, the written value is taken verbatim.
  - With a SET/CLR write, the expiry clear is applied first, then the set/clear.
  - With a PULSE write, the retrigger wins: no clear, and the counter is reloaded.
- Input path: in_port passes through sync1 and then sync2. IN reads sync2. A third flop, prev, holds sync2 delayed by one cycle.
- Edge capture (PIO_EDGE_IRQ_EN only):
  - edge = sync2 & ~prev.
  - EDGE |= edge each cycle.
  - A write-1-clear on the same cycle as a new edge on the same bit leaves the bit set.
  - irq = |(EDGE & IRQMASK), driven from registers.

## Timing
- Reset values (sampled on the clk edge with reset_n=0):
  - DATA=RESET_VALUE, so out_port=RESET_VALUE.
  - sync1, sync2, prev, EDGE, IRQMASK, pulse_mask and count = 0.
  - PULSE_LEN=1. irq=0.
  - readdata follows the reset state combinationally.
- Reset asserted mid-pulse aborts the pulse. out_port returns to RESET_VALUE on the next edge.
- Write to out_port latency is 1 cycle: visible the cycle after the write edge.
- Pulse width: bits written via PULSE are high for exactly max(PULSE_LEN,1) cycles.
- in_port to IN latency is 2 cycles.
- in_port rise to EDGE bit set is 3 cycles.
- EDGE set to irq is 0 additional cycles; irq is combinational from the EDGE and IRQMASK flops.
- Reads return the state as of the current cycle. A write and a read to the same cycle cannot both occur (Avalon single command per cycle).

## Configuration
- PIO_EDGE_IRQ_EN
  - Defined: EDGE, IRQMASK, the prev flop and irq logic are present as described.
  - Undefined: these are removed. Addresses 4 and 5 read 0, writes to them are ignored, and irq is tied 0.
  - DATA, SET, CLR, IN and the pulse engine are unaffected in both cases.

## Test plan
- Reset with RESET_VALUE=8'hA5. Write DATA=0x3C, then SET 0x81, then CLR 0x0C → out_port reads A5, then 3C, then BD, then B1, each one cycle after its write.
- PULSE_LEN=4, DATA=0x00, write PULSE=0x01 → out_port[0] high exactly 4 cycles. Reads of address 7 return 4,3,2,1, then 0.
- Pulse retrigger and collision:
  - PULSE_LEN=3. PULSE=0x01, then 2 cycles later PULSE=0x02 → both bits high until 3 cycles after the second write, then clear together.
  - A separate run with a SET 0x01 on the expiry cycle → bit 0 stays 1.
- in_port[2] rises once, IRQMASK=0x04 → EDGE=0x04 and irq=1 three cycles later. Write EDGE=0x04 → irq=0 next cycle. A new edge coinciding with the clear → EDGE stays 0x04.
- Drive reset_n=0 for one cycle in the middle of a 10-cycle pulse → out_port=RESET_VALUE and count=0 next cycle. Later PULSE writes behave normally.
- Build without PIO_EDGE_IRQ_EN and toggle in_port → irq stays 0, addresses 4/5 read 0, and IN tracks in_port with 2-cycle delay.

Source files
------------

// File: rtl/avalon_pio_ctrl.sv
// avalon_pio_ctrl: Avalon-MM PIO with set/clear, self-timed pulses and synchronised inputs; `PIO_EDGE_IRQ_EN adds edge capture and irq
module avalon_pio_ctrl #(
    parameter int                DATA_W      = 8,
    parameter int                PULSE_W     = 8,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic              irq
);
    typedef enum logic {S_IDLE, S_ACTIVE} state_t;
    state_t             r_state, w_state_nxt;
    logic [DATA_W-1:0]  r_data, r_sync1, r_sync2, r_pulse_mask;
    logic [DATA_W-1:0]  w_data_nxt, w_mask_nxt, w_base, w_wd;
    logic [PULSE_W-1:0] r_pulse_len, r_count, w_count_nxt, w_len_eff;
    logic [31:0]        w_rd_edge, w_rd_mask;
    logic               w_wr, w_pulse_wr, w_expire;
    logic               w_unused_wd;

    assign w_wr        = chipselect & ~write_n;
    assign w_wd        = writedata[DATA_W-1:0];
    assign w_unused_wd = ^writedata;
    assign out_port    = r_data;

    // Pulse engine next state and output-register update; a retrigger suppresses expiry
    always_comb begin
        w_pulse_wr  = w_wr && address == 3'd7;
        w_len_eff   = (r_pulse_len == '0) ? PULSE_W'(1) : r_pulse_len;
        w_expire    = (r_state == S_ACTIVE) && (r_count == PULSE_W'(1)) && !w_pulse_wr;
        w_base      = w_expire ? (r_data & ~r_pulse_mask) : r_data;
        w_count_nxt = w_pulse_wr ? w_len_eff : (r_state == S_ACTIVE) ? r_count - PULSE_W'(1) : '0;
        w_mask_nxt  = w_pulse_wr ? (r_pulse_mask | w_wd) : w_expire ? '0 : r_pulse_mask;
        w_state_nxt = (w_count_nxt != '0) ? S_ACTIVE : S_IDLE;
        w_data_nxt  = (w_wr && address == 3'd0) ? w_wd
                    : (w_wr && address == 3'd2) ? (w_base | w_wd)
                    : (w_wr && address == 3'd3) ? (w_base & ~w_wd)
                    : w_pulse_wr ? (w_base | w_wd) : w_base;
    end

    // Output register, pulse state/count/mask and pulse length
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_data       <= RESET_VALUE;
            r_pulse_mask <= '0;
            r_count      <= '0;
            r_pulse_len  <= PULSE_W'(1);
        end else begin
            r_state      <= w_state_nxt;
            r_data       <= w_data_nxt;
            r_pulse_mask <= w_mask_nxt;
            r_count      <= w_count_nxt;
            if (w_wr && address == 3'd6)
                r_pulse_len <= writedata[PULSE_W-1:0];
        end
    end

    // Two-flop synchroniser for the asynchronous status inputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PIO_EDGE_IRQ_EN
    logic [DATA_W-1:0] r_prev, r_edge, r_irqmask, w_edge_clr;

    assign w_edge_clr = (w_wr && address == 3'd4) ? w_wd : '0;
    assign irq        = |(r_edge & r_irqmask);
    assign w_rd_edge  = 32'(r_edge);
    assign w_rd_mask  = 32'(r_irqmask);

    // Rising-edge capture; a new edge wins over a same-cycle write-1-clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev    <= '0;
            r_edge    <= '0;
            r_irqmask <= '0;
        end else begin
            r_prev <= r_sync2;
            r_edge <= (r_edge & ~w_edge_clr) | (r_sync2 & ~r_prev);
            if (w_wr && address == 3'd5)
                r_irqmask <= w_wd;
        end
    end
`else
    assign irq       = 1'b0;
    assign w_rd_edge = '0;
    assign w_rd_mask = '0;
`endif

    // Zero-wait-state read mux; write-only and unused bits read as 0
    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata = 32'(r_data);
            3'd1:    readdata = 32'(r_sync2);
            3'd4:    readdata = w_rd_edge;
            3'd5:    readdata = w_rd_mask;
            3'd6:    readdata = 32'(r_pulse_len);
            3'd7:    readdata = 32'(r_count);
            default: readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_avalon_pio_ctrl.sv
// tb_avalon_pio_ctrl: directed and random checks of avalon_pio_ctrl against a cycle-count reference model
module tb_avalon_pio_ctrl;
    localparam logic [7:0] RV = 8'hA5;
`ifdef PIO_EDGE_IRQ_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write_n = 1'b1;
    logic [2:0]  address = '0;
    logic [31:0] writedata = '0, readdata;
    logic [7:0]  in_port = '0, out_port;
    logic        irq;
    int          n_tests = 0, n_fail = 0;

    logic [7:0]  m_data, m_mask, m_len, m_edge, m_irqmask;
    int          cyc = 0, m_end = 0;
    logic [7:0]  hist[$];

    avalon_pio_ctrl #(.DATA_W(8), .PULSE_W(8), .RESET_VALUE(RV)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic m_irq();
        return EN && ((m_edge & m_irqmask) != 8'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd1:    return 32'(hist[1]);
            3'd4:    return EN ? 32'(m_edge) : 32'd0;
            3'd5:    return EN ? 32'(m_irqmask) : 32'd0;
            3'd6:    return 32'(m_len);
            3'd7:    return (m_end > cyc) ? 32'(m_end - cyc) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [2:0] a, input logic wr, input logic [31:0] wd);
        logic       pw;
        logic [7:0] w;
        address = a; chipselect = wr; write_n = !wr; writedata = wd;
        @(posedge clk);
        cyc++;
        w = wd[7:0];
        if (!reset_n) begin
            m_data = RV; m_mask = 0; m_end = cyc; m_len = 1; m_edge = 0; m_irqmask = 0;
            hist.delete();
            repeat (3) hist.push_back(8'd0);
        end else begin
            pw = wr && a == 3'd7;
            m_edge = (m_edge & ~((wr && a == 3'd4) ? w : 8'd0)) | (hist[1] & ~hist[2]);
            if (!pw && m_end == cyc) begin
                m_data &= ~m_mask;
                m_mask = 0;
            end
            if (wr) begin
                case (a)
                    3'd0: m_data = w;
                    3'd2: m_data |= w;
                    3'd3: m_data &= ~w;
                    3'd5: m_irqmask = w;
                    3'd6: m_len = w;
                    3'd7: begin
                        m_data |= w;
                        m_mask |= w;
                        m_end = cyc + ((m_len == 0) ? 1 : int'(m_len));
                    end
                    default: ;
                endcase
            end
            hist.push_front(in_port);
            void'(hist.pop_back());
        end
        #1;
        chipselect = 1'b0; write_n = 1'b1;
        chk("out_port", 32'(out_port), 32'(m_data));
        chk("irq", 32'(irq), 32'(m_irq()));
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        #1;
        chk($sformatf("read addr %0d", a), readdata, m_read(a));
    endtask

    initial begin
        logic [2:0]  ra;
        logic [31:0] rw;
        logic        rwr;
        reset_n = 1'b0;
        tick(0, 0, 0); tick(0, 0, 0);
        reset_n = 1'b1;
        chk("reset out_port", 32'(out_port), 32'(RV));
        for (int a = 0; a < 8; a++) rd(3'(a));

        tick(0, 1, 'h3C); chk("data write", 32'(out_port), 32'h3C);
        tick(2, 1, 'h81); chk("set", 32'(out_port), 32'hBD);
        tick(3, 1, 'h0C); chk("clr", 32'(out_port), 32'hB1);
        rd(2); rd(3);

        tick(6, 1, 4); rd(6);
        tick(0, 1, 0);
        tick(7, 1, 1); rd(7);
        for (int i = 0; i < 5; i++) begin tick(0, 0, 0); rd(7); end

        tick(6, 1, 3);
        tick(7, 1, 1); tick(0, 0, 0);
        tick(7, 1, 2); rd(7);
        for (int i = 0; i < 4; i++) begin tick(0, 0, 0); rd(7); end

        tick(0, 1, 0);
        tick(7, 1, 1); tick(0, 0, 0); tick(0, 0, 0);
        tick(2, 1, 1); chk("set at expiry bit0", 32'(out_port[0]), 32'd1);
        tick(0, 1, 0);
        tick(7, 1, 6); tick(0, 0, 0); tick(0, 0, 0);
        tick(0, 1, 4); chk("data at expiry", 32'(out_port), 32'h04);
        tick(0, 1, 0);
        tick(7, 1, 1); tick(0, 0, 0); tick(0, 0, 0);
        tick(7, 1, 8); rd(7);
        for (int i = 0; i < 4; i++) tick(0, 0, 0);

        tick(5, 1, 4); rd(5);
        in_port = 8'h04;
        tick(0, 0, 0); tick(0, 0, 0); rd(1);
        tick(0, 0, 0); rd(4);
        tick(4, 1, 4); rd(4);
        in_port = 8'h00;
        repeat (3) tick(0, 0, 0);
        in_port = 8'h04;
        tick(0, 0, 0); tick(0, 0, 0);
        tick(4, 1, 4); rd(4);
        in_port = 8'h5A;
        tick(0, 0, 0); tick(0, 0, 0); rd(1); rd(4);

        tick(6, 1, 10);
        tick(0, 1, 0);
        tick(7, 1, 'h30); tick(0, 0, 0); tick(0, 0, 0);
        reset_n = 1'b0;
        tick(0, 0, 0);
        reset_n = 1'b1;
        chk("mid-pulse reset out_port", 32'(out_port), 32'(RV));
        rd(7); rd(6); rd(4);
        tick(7, 1, 2); rd(7);
        for (int i = 0; i < 3; i++) begin tick(0, 0, 0); rd(0); end

        for (int i = 0; i < 400; i++) begin
            ra  = 3'($urandom_range(0, 7));
            rwr = ($urandom_range(0, 2) != 0);
            rw  = $urandom;
            if (ra == 3'd6) rw = $urandom_range(0, 5);
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            reset_n = ($urandom_range(0, 60) != 0);
            tick(ra, rwr, rw);
            reset_n = 1'b1;
            rd(3'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
